bringup_sequencer: RTL

Parametrised power-on bring-up controller for the top level. It takes N ordered readiness sources (e.g. rPLL lock, then PSRAM init calibration) and enables each stage only after the previous stage is ready and stable. Each stage has a watchdog timeout, a debounce/settle window and loss-of-ready monitoring. It drives a single all_ready plus error status to the rest of the design. This generalises the fixed "wait for lock, then wait for calib" bring-up sequence into an N-stage sequencer with timeouts and recovery.

---
 rtl/bringup_pkg.sv | 10 +
 rtl/lowest_zero_index.sv | 18 +
 rtl/bringup_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bringup_pkg.sv
// bringup_pkg: shared state type, error codes and index-width helper for the bring-up sequencer
package bringup_pkg;
    typedef enum logic [1:0] {WAIT, SETTLE, DONE, ERROR} state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LOST = 2'd2;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lowest_zero_index.sv
// lowest_zero_index: priority encoder returning the lowest cleared bit of a vector
module lowest_zero_index
    import bringup_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] bits,
    output logic         found,
    output logic [W-1:0] idx
);
    always_comb begin
        found = ~&bits;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (!bits[i]) idx = W'(i);
    end
endmodule

// File: rtl/bringup_sequencer.sv
// bringup_sequencer: N-stage ordered power-on bring-up with per-stage settle window,
// watchdog timeout and loss-of-ready monitoring
module bringup_sequencer
    import bringup_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SETTLE_CYCLES = 16,
    localparam int SW = idx_w(STAGES)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [STAGES-1:0] stage_ready,
    input  logic              retry,
    output logic [STAGES-1:0] stage_enable,
    output logic              all_ready,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [SW-1:0]     error_stage,
    output logic [SW-1:0]     current_stage
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] S_MAX = CW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

    state_t state, state_n;
    logic [SW-1:0] stage, stage_n, estage_n, lost_idx;
    logic [TW-1:0] t_cnt, t_n, t_inc;
    logic [CW-1:0] s_cnt, s_n;
    logic [1:0] code_n;
    logic [STAGES-1:0] watch;
    logic lost, ready_s, t_exp, settled;

    function automatic logic [STAGES-1:0] upto(input int s);
        logic [STAGES-1:0] r;
        for (int i = 0; i < STAGES; i++) r[i] = i <= s;
        return r;
    endfunction

    assign ready_s = stage_ready[stage];
    assign t_inc = (t_cnt == T_MAX) ? t_cnt : t_cnt + TW'(1);
    assign t_exp = t_inc == T_MAX;
    assign settled = s_cnt == S_MAX;
    // earlier stages are watched while waiting; every stage is watched once done
    assign watch = state == DONE ? '1 : state == ERROR ? '0 : upto(int'(stage) - 1);

    lowest_zero_index #(.N(STAGES), .W(SW)) u_lzi (
        .bits (stage_ready | ~watch),
        .found(lost),
        .idx  (lost_idx)
    );

    always_comb begin
        state_n = state;
        stage_n = stage;
        t_n = t_cnt;
        s_n = s_cnt;
        code_n = error_code;
        estage_n = error_stage;
        case (state)
            WAIT, SETTLE: begin
                t_n = t_inc;
                if (lost) begin
                    state_n = ERROR;
                    code_n = ERR_LOST;
                    estage_n = lost_idx;
                end else if (state == SETTLE && ready_s && settled) begin
                    state_n = stage == LAST ? DONE : WAIT;
                    stage_n = stage == LAST ? stage : stage + SW'(1);
                    t_n = '0;
                    s_n = '0;
                end else if (t_exp && !(state == WAIT && ready_s)) begin
                    state_n = ERROR;
                    code_n = ERR_TIMEOUT;
                    estage_n = stage;
                end else begin
                    state_n = ready_s ? SETTLE : WAIT;
                    s_n = !ready_s ? '0 : state == SETTLE ? s_cnt + CW'(1) : CW'(1);
                end
            end
            DONE: begin
                if (lost) begin
                    state_n = ERROR;
                    code_n = ERR_LOST;
                    estage_n = lost_idx;
                end
            end
            ERROR: begin
                if (retry) begin
                    state_n = WAIT;
                    stage_n = '0;
                    t_n = '0;
                    s_n = '0;
                    code_n = ERR_NONE;
                    estage_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= WAIT;
            stage <= '0;
            t_cnt <= '0;
            s_cnt <= '0;
            stage_enable <= '0;
            all_ready <= 1'b0;
            error <= 1'b0;
            error_code <= ERR_NONE;
            error_stage <= '0;
            current_stage <= '0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            t_cnt <= t_n;
            s_cnt <= s_n;
            stage_enable <= state_n == DONE ? '1 : state_n == ERROR ? '0 : upto(int'(stage_n));
            all_ready <= state_n == DONE;
            error <= state_n == ERROR;
            error_code <= code_n;
            error_stage <= estage_n;
            current_stage <= stage_n;
        end
    end
endmodule
